// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA sync receiver.
//   lock_state_t : lock FSM encoding (SEARCH / CHECK / LOCKED)
//   DEF_*        : default 800x600@72 porch and active-area constants
//                  (1040 clocks/line with 120 hs clocks, 666 lines/frame
//                  with 6 vs lines)
//   sat_inc()    : 16-bit increment that sticks at all-ones instead of wrapping
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  localparam int unsigned DEF_HBP = 64;
  localparam int unsigned DEF_HEN = 800;
  localparam int unsigned DEF_VBP = 23;
  localparam int unsigned DEF_VEN = 600;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_edge_meas.sv
// Registers one sync input, detects its rising edge and measures its period
// and high width. Time advances only on cycles with en=1, so the same block
// counts pixel clocks for hs (en tied high) and lines for vs (en = hs rise).
//   clk, rst_n  : pixel clock, async active-low reset
//   sig         : sync input, active high
//   en          : sample strobe
//   rise        : sig seen 1 while the registered copy was 0 (this strobe)
//   cnt         : strobes since the last rise (0 on the rise strobe)
//   period_nxt  : period ending at this rise (cnt+1), valid when rise=1
//   width       : strobes the sync was high, loaded at its falling edge
module sync_edge_meas
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig,
  input  logic        en,
  output logic        rise,
  output logic [15:0] cnt,
  output logic [15:0] period_nxt,
  output logic [15:0] width
);

  logic        sig_q;
  logic        fall;
  logic [15:0] wcnt;

  assign rise       = en &  sig & ~sig_q;
  assign fall       = en & ~sig &  sig_q;
  assign period_nxt = sat_inc(cnt);

  // NOTE: sequential state uses <= only, so every branch below reads the
  // pre-edge values of sig_q/cnt/wcnt regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
      cnt   <= '0;
      wcnt  <= '0;
      width <= '0;
    end else if (en) begin
      sig_q <= sig;
      cnt   <= rise ? '0 : sat_inc(cnt);
      // wcnt counts strobes with sig_q=1; the falling strobe is the last one.
      if (fall) begin
        width <= sat_inc(wcnt);
        wcnt  <= '0;
      end else if (sig_q) begin
        wcnt  <= sat_inc(wcnt);
      end
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing from hs/vs, locks once two
// consecutive frames measure identically, and produces de/x/y for the
// active area.
//   clk, rst_n          : pixel clock, async active-low reset
//   hs, vs              : active-high syncs, synchronous to clk
//   h_total, h_sync     : locked candidate, clocks per line / hs-high clocks
//   v_total, v_sync     : locked candidate, lines per frame / vs-high lines
//   locked              : timing stable (FSM in LOCKED)
//   de, x, y            : active pixel flag and coordinates, 1 clock latency
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int unsigned HBP = DEF_HBP,
  parameter int unsigned HEN = DEF_HEN,
  parameter int unsigned VBP = DEF_VBP,
  parameter int unsigned VEN = DEF_VEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  output logic [15:0] h_total,
  output logic [15:0] h_sync,
  output logic [15:0] v_total,
  output logic [15:0] v_sync,
  output logic        locked,
  output logic        de,
  output logic [15:0] x,
  output logic [15:0] y
);

  logic        hs_rise, vs_rise;
  logic [15:0] hcnt, lcnt;
  logic [15:0] h_len, h_wid, v_len, v_wid;
  logic        hcnt_sat, frame_match;
  lock_state_t state;

  sync_edge_meas u_hs_meas (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig        (hs),
    .en         (1'b1),
    .rise       (hs_rise),
    .cnt        (hcnt),
    .period_nxt (h_len),
    .width      (h_wid)
  );

  // vs is only looked at on hs rises, so its counter is the line number.
  sync_edge_meas u_vs_meas (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig        (vs),
    .en         (hs_rise),
    .rise       (vs_rise),
    .cnt        (lcnt),
    .period_nxt (v_len),
    .width      (v_wid)
  );

  // An hs rise on the saturating edge is a (very long) line, not a loss.
  assign hcnt_sat    = (hcnt == CNT_MAX) && !hs_rise;
  assign frame_match = (h_len == h_total) && (h_wid == h_sync) &&
                       (v_len == v_total) && (v_wid == v_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      locked  <= 1'b0;
      h_total <= '0;
      h_sync  <= '0;
      v_total <= '0;
      v_sync  <= '0;
    end else if (hcnt_sat) begin
      // Clearing the candidate forces a full re-measure after hs returns.
      state   <= SEARCH;
      locked  <= 1'b0;
      h_total <= '0;
      h_sync  <= '0;
      v_total <= '0;
      v_sync  <= '0;
    end else begin
      case (state)
        SEARCH: begin
          // The first frame boundary only starts a measurement.
          if (vs_rise) state <= CHECK;
        end
        CHECK: begin
          if (vs_rise) begin
            h_total <= h_len;
            h_sync  <= h_wid;
            v_total <= v_len;
            v_sync  <= v_wid;
            if (frame_match) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (vs_rise && !frame_match) begin
            state   <= CHECK;
            locked  <= 1'b0;
            h_total <= h_len;
            h_sync  <= h_wid;
            v_total <= v_len;
            v_sync  <= v_wid;
          end else if (!vs_rise && hs_rise && (h_len != h_total)) begin
            // Mid-frame the line count is partial, so only the horizontal
            // half of the candidate is refreshed here.
            state   <= CHECK;
            locked  <= 1'b0;
            h_total <= h_len;
            h_sync  <= h_wid;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  logic [15:0] h_start, h_stop, v_start, v_stop;
  logic        de_nxt;

  assign h_start = h_sync + 16'(HBP);
  assign h_stop  = h_start + 16'(HEN);
  assign v_start = v_sync + 16'(VBP);
  assign v_stop  = v_start + 16'(VEN);

  assign de_nxt = locked &&
                  (hcnt >= h_start) && (hcnt < h_stop) &&
                  (lcnt >= v_start) && (lcnt < v_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de <= 1'b0;
      x  <= '0;
      y  <= '0;
    end else begin
      de <= de_nxt;
      x  <= de_nxt ? hcnt - h_start : '0;
      y  <= de_nxt ? lcnt - v_start : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced timing so whole frames fit
// in a short run: 32 clocks/line (hs high 3), 16 lines/frame (vs high 2),
// HBP=4 HEN=20 VBP=2 VEN=10. Active pixels: de after edges 8..27 of a line
// (hcnt 7..26), rows 4..13.
module tb_vga_sync_rx;
  import vga_timing_pkg::*;

  localparam int H_TOT     = 32;
  localparam int H_SW      = 3;
  localparam int V_TOT     = 16;
  localparam int V_SW      = 2;
  localparam int DE_FIRST  = 8;
  localparam int DE_LAST   = 27;
  localparam int ROW_FIRST = 4;
  localparam int ROW_LAST  = 13;

  logic        clk = 1'b0;
  logic        rst_n, hs, vs;
  logic [15:0] h_total, h_sync, v_total, v_sync, x, y;
  logic        locked, de;
  logic        lk;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_rx #(.HBP(4), .HEN(20), .VBP(2), .VEN(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hs      (hs),
    .vs      (vs),
    .h_total (h_total),
    .h_sync  (h_sync),
    .v_total (v_total),
    .v_sync  (v_sync),
    .locked  (locked),
    .de      (de),
    .x       (x),
    .y       (y)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs for the next rising edge, then sample 1 ns after it.
  task automatic clk_edge(input logic h, input logic v);
    @(negedge clk);
    hs = h;
    vs = v;
    @(posedge clk);
    #1;
  endtask

  // One line; lk0 is locked as seen right after this line's hs rise.
  task automatic send_line(input int len, input int row, input bit scan, output logic lk0);
    logic exp_de;
    lk0 = 1'b0;
    for (int i = 0; i < len; i++) begin
      clk_edge(i < H_SW, row < V_SW);
      if (i == 0) lk0 = locked;
      if (scan) begin
        exp_de = (row >= ROW_FIRST) && (row <= ROW_LAST) &&
                 (i >= DE_FIRST) && (i <= DE_LAST);
        check("scan_de", de, exp_de);
        check("scan_x", x, exp_de ? 16'(i - DE_FIRST) : 16'd0);
        check("scan_y", y, exp_de ? 16'(row - ROW_FIRST) : 16'd0);
      end
    end
  endtask

  task automatic send_frame(input bit scan, output logic lk0);
    logic l;
    lk0 = 1'b0;
    for (int r = 0; r < V_TOT; r++) begin
      send_line(H_TOT, r, scan, l);
      if (r == 0) lk0 = l;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},  locked,  16'd0);
    check({tag, "_h_total"}, h_total, 16'd0);
    check({tag, "_h_sync"},  h_sync,  16'd0);
    check({tag, "_v_total"}, v_total, 16'd0);
    check({tag, "_v_sync"},  v_sync,  16'd0);
    check({tag, "_de"},      de,      16'd0);
    check({tag, "_x"},       x,       16'd0);
    check({tag, "_y"},       y,       16'd0);
    check({tag, "_state"},   dut.state, SEARCH);
  endtask

  initial begin
    hs    = 1'b0;
    vs    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First vs rise only arms the measurement; the second latches a
    // candidate; the third confirms it.
    send_frame(1'b0, lk);
    check("rise1_locked", lk, 16'd0);
    check("rise1_state", dut.state, CHECK);
    send_frame(1'b0, lk);
    check("rise2_locked", lk, 16'd0);
    check("rise2_h_total", h_total, 16'd32);
    send_frame(1'b0, lk);
    check("rise3_locked", lk, 16'd1);
    check("lock_h_total", h_total, 16'd32);
    check("lock_h_sync", h_sync, 16'd3);
    check("lock_v_total", v_total, 16'd16);
    check("lock_v_sync", v_sync, 16'd2);

    // Full-frame de/x/y scan while locked.
    send_frame(1'b1, lk);
    check("scan_locked", lk, 16'd1);

    // Line 5 is one clock short.
    for (int r = 0; r < 5; r++) send_line(H_TOT, r, 1'b0, lk);
    send_line(H_TOT - 1, 5, 1'b0, lk);
    check("short_before", lk, 16'd1);
    send_line(H_TOT, 6, 1'b0, lk);
    check("short_unlock", lk, 16'd0);
    check("short_h_total", h_total, 16'd31);
    for (int r = 7; r < V_TOT; r++) send_line(H_TOT, r, 1'b0, lk);
    send_frame(1'b0, lk);
    check("clean1_locked", lk, 16'd0);
    send_frame(1'b0, lk);
    check("clean2_locked", locked, 16'd1);
    check("clean2_h_total", h_total, 16'd32);

    // hs stuck low: 31 edges since the last rise plus 65500 keeps hcnt
    // below saturation; 10 more edges pass it.
    repeat (65500) clk_edge(1'b0, 1'b0);
    check("sat_before", locked, 16'd1);
    repeat (10) clk_edge(1'b0, 1'b0);
    check("sat_locked", locked, 16'd0);
    check("sat_state", dut.state, SEARCH);
    check("sat_de", de, 16'd0);
    send_frame(1'b0, lk);
    send_frame(1'b0, lk);
    check("sat_relock2", lk, 16'd0);
    send_frame(1'b0, lk);
    check("sat_relock3", lk, 16'd1);

    // Reset pulse between clock edges inside the active area.
    for (int r = 0; r < 4; r++) send_line(H_TOT, r, 1'b0, lk);
    for (int i = 0; i < 12; i++) clk_edge(i < H_SW, 1'b0);
    check("pre_rst_de", de, 16'd1);
    check("pre_rst_x", x, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 12; i < H_TOT; i++) clk_edge(1'b0, 1'b0);
    for (int r = 5; r < V_TOT; r++) send_line(H_TOT, r, 1'b0, lk);
    send_frame(1'b0, lk);
    check("rst_relock1", lk, 16'd0);
    send_frame(1'b0, lk);
    check("rst_relock2", lk, 16'd0);
    send_frame(1'b0, lk);
    check("rst_relock3", lk, 16'd1);
    check("rst_h_total", h_total, 16'd32);
    check("rst_v_total", v_total, 16'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
